// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// The optional IFQ_PERF_CNT_EN feature lives in ifetch_queue.sv.
package ifq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam logic [31:0] WORD_BYTES       = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifq_if.sv
// Fetch-side bus: instruction memory handshake, redirect and decode handshake.
// master = fetch queue, slave = environment (memory, decode, branch unit).
interface ifq_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    input  imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, pc_plus4_o,
    output imem_ack_i, imem_data_i, redirect_i, redirect_pc_i, instr_ready_i
  );
endinterface

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc, instr} entries with clear; clear beats push and pop.
// The read port is a register-array read, so it never sees write data combinationally.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem[wr_ptr_r] <= wdata;
        wr_ptr_r      <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: sequential PC generation, imem handshake, FIFO, redirect.
// Define IFQ_PERF_CNT_EN to add the stall_cnt_o performance counter.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  ifq_if.master       bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e        state_r;
  state_e        state_s;
  logic [31:0]   fetch_pc_r;
  logic [31:0]   old_addr_r;
  logic [CW-1:0] count_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic          room_after_push_s;
  entry_t        head_s;
  entry_t        wdata_s;

  assign push_s  = (state_r == REQ) && bus.imem_ack_i && !bus.redirect_i;
  assign pop_s   = !empty_s && bus.instr_ready_i && !bus.redirect_i;
  assign wdata_s = '{pc: fetch_pc_r, instr: bus.imem_data_i};
  // A pop in the ack cycle is deliberately not credited here.
  assign room_after_push_s = ((count_s + CW'(1)) < CW'(DEPTH));

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push_s),
    .pop   (pop_s),
    .clear (bus.redirect_i),
    .wdata (wdata_s),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!bus.redirect_i && !full_s) state_s = REQ;
        else                            state_s = IDLE;
      end
      REQ: begin
        if (bus.redirect_i)      state_s = bus.imem_ack_i ? REQ : DROP;
        else if (bus.imem_ack_i) state_s = room_after_push_s ? REQ : IDLE;
        else                     state_s = REQ;
      end
      DROP: begin
        if (bus.imem_ack_i) state_s = REQ;
        else                state_s = DROP;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: DROP keeps presenting the abandoned address until it is acked.
  always_comb begin
    bus.imem_req_o  = 1'b0;
    bus.imem_addr_o = fetch_pc_r;
    case (state_r)
      IDLE: begin
        bus.imem_req_o  = 1'b0;
        bus.imem_addr_o = fetch_pc_r;
      end
      REQ: begin
        bus.imem_req_o  = 1'b1;
        bus.imem_addr_o = fetch_pc_r;
      end
      DROP: begin
        bus.imem_req_o  = 1'b1;
        bus.imem_addr_o = old_addr_r;
      end
      default: begin
        bus.imem_req_o  = 1'b0;
        bus.imem_addr_o = fetch_pc_r;
      end
    endcase
  end

  // Fetch PC and the address of a request orphaned by a redirect.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_pc_r <= RESET_PC;
      old_addr_r <= RESET_PC;
    end else begin
      if (bus.redirect_i) begin
        fetch_pc_r <= align_pc(bus.redirect_pc_i);
      end else if (push_s) begin
        fetch_pc_r <= fetch_pc_r + WORD_BYTES;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
      if ((state_r == REQ) && bus.redirect_i && !bus.imem_ack_i) begin
        old_addr_r <= fetch_pc_r;
      end else begin
        old_addr_r <= old_addr_r;
      end
    end
  end

  assign bus.instr_valid_o = !empty_s;
  assign bus.instr_o       = head_s.instr;
  assign bus.pc_o          = head_s.pc;
  assign bus.pc_plus4_o    = head_s.pc + WORD_BYTES;

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles where decode is ready but nothing is presented.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'd0;
    end else if (bus.instr_ready_i && empty_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a PC-stream reference model pushes expected
// entries on accepted acks, an independent monitor pops and compares at the head.
module tb_ifetch_queue;
  import ifq_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ifq_if bus ();
`ifdef IFQ_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef IFQ_PERF_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  entry_t      exp_q[$];
  logic [31:0] model_pc     = RPC;
  bit          drop_pending = 1'b0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr    = 32'd0;
  bit          popped_now   = 1'b0;
  int          starve       = 0;
  int          pops         = 0;
  logic [31:0] stall_exp    = 32'd0;

  int lat_min = 0, lat_max = 0, cur_lat = 0, wait_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven at the falling edge; memory answers after cur_lat waits.
  task automatic step(input bit rd, input logic [31:0] tgt, input bit rdy);
    @(negedge clk);
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rd ? tgt : $urandom;
    bus.instr_ready_i = rdy;
    bus.imem_ack_i    = 1'b0;
    bus.imem_data_i   = $urandom;
    if (bus.imem_req_o && !rst) begin
      if (wait_cnt >= cur_lat) begin
        bus.imem_ack_i = 1'b1;
        wait_cnt       = 0;
        cur_lat        = $urandom_range(lat_max, lat_min);
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  endtask

  task automatic set_lat(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    cur_lat = hi;
  endtask

  // Monitor: compare head against the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        popped_now = 1'b0;
        stall_exp  = 32'd0;
      end else begin
        chk("valid", {31'd0, bus.instr_valid_o}, {31'd0, exp_q.size() != 0});
        if (bus.instr_valid_o && exp_q.size() > 0) begin
          chk("pc", bus.pc_o, exp_q[0].pc);
          chk("instr", bus.instr_o, exp_q[0].instr);
          chk("pc_plus4", bus.pc_plus4_o, exp_q[0].pc + 32'd4);
        end
        popped_now = bus.instr_valid_o && bus.instr_ready_i && !bus.redirect_i && exp_q.size() > 0;
        if (popped_now) begin
          void'(exp_q.pop_front());
          pops++;
        end
`ifdef IFQ_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, stall_exp);
        if (bus.instr_ready_i && exp_q.size() == 0 && stall_exp != 32'hFFFF_FFFF) stall_exp++;
`endif
      end
    end
  end

  // Reference model: expected PC stream, drop of orphaned acks, issue rule.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        exp_q.delete();
        model_pc     = RPC;
        drop_pending = 1'b0;
        prev_pending = 1'b0;
        starve       = 0;
      end else begin
        if (prev_pending) begin
          chk("req_held", {31'd0, bus.imem_req_o}, 32'd1);
          chk("addr_held", bus.imem_addr_o, prev_addr);
        end
        if (bus.imem_ack_i) begin
          if (bus.redirect_i || drop_pending) begin
            drop_pending = 1'b0;
          end else begin
            chk("fetch_addr", bus.imem_addr_o, model_pc);
            chk("room_on_issue", {31'd0, (exp_q.size() + int'(popped_now)) < DEPTH}, 32'd1);
            exp_q.push_back('{pc: model_pc, instr: bus.imem_data_i});
            model_pc = model_pc + 32'd4;
          end
        end
        if (bus.redirect_i) begin
          exp_q.delete();
          model_pc = {bus.redirect_pc_i[31:2], 2'b00};
          if (bus.imem_req_o && !bus.imem_ack_i) drop_pending = 1'b1;
          starve = 0;
        end else if (!bus.imem_req_o && exp_q.size() < DEPTH) begin
          starve++;
        end else begin
          starve = 0;
        end
        if (starve > 2) chk("issue_stalled", {31'd0, bus.imem_req_o}, 32'd1);
        prev_pending = bus.imem_req_o && !bus.imem_ack_i;
        prev_addr    = bus.imem_addr_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    bus.imem_ack_i    = 1'b0;
    bus.imem_data_i   = 32'd0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'd0;
    bus.instr_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, RPC);
    chk("rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("rst_instr", bus.instr_o, 32'd0);
    chk("rst_pc", bus.pc_o, 32'd0);
    chk("rst_pc4", bus.pc_plus4_o, 32'd4);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with immediate acks.
    set_lat(0, 0);
    repeat (20) step(1'b0, 32'd0, 1'b1);

    // Back-pressure: fill, then drain.
    repeat (15) step(1'b0, 32'd0, 1'b0);
    #1;
    chk("full_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("full_valid", {31'd0, bus.instr_valid_o}, 32'd1);
    repeat (20) step(1'b0, 32'd0, 1'b1);

    // Redirect while a slow request to 0x8 is outstanding.
    step(1'b1, 32'd0, 1'b1);
    set_lat(3, 3);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.imem_req_o && bus.imem_addr_o == 32'h8 && wait_cnt == 0) found = 1'b1;
      else step(1'b0, 32'd0, 1'b1);
    end
    chk("found_req8", {31'd0, found}, 32'd1);
    step(1'b1, 32'h0000_0102, 1'b1);
    repeat (25) step(1'b0, 32'd0, 1'b1);

    // Redirect coincident with an ack and a pop.
    set_lat(0, 0);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.imem_req_o && bus.instr_valid_o) found = 1'b1;
      else step(1'b0, 32'd0, 1'b1);
    end
    chk("found_ack_pop", {31'd0, found}, 32'd1);
    step(1'b1, 32'h0000_0040, 1'b1);
    chk("ack_with_redirect", {31'd0, bus.imem_ack_i}, 32'd1);
    step(1'b0, 32'd0, 1'b1);
    #1;
    chk("flushed_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    repeat (10) step(1'b0, 32'd0, 1'b1);

    // Address wrap.
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (12) step(1'b0, 32'd0, 1'b1);

    // Random traffic.
    set_lat(0, 3);
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(19, 0) == 0), $urandom, $urandom_range(1, 0) == 1);
    end

    // Asynchronous reset in the middle of a request.
    set_lat(2, 2);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.imem_req_o) found = 1'b1;
      else step(1'b0, 32'd0, 1'b1);
    end
    chk("found_req_for_rst", {31'd0, found}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("async_rst_valid", {31'd0, bus.instr_valid_o}, 32'd0);
    chk("async_rst_addr", bus.imem_addr_o, RPC);
    chk("async_rst_pc4", bus.pc_plus4_o, 32'd4);
    repeat (2) step(1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    set_lat(0, 1);
    repeat (30) step(1'b0, 32'd0, 1'b1);

    chk("enough_pops", {31'd0, pops > 100}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
